// File: rtl/rd_burst_arbiter.sv
// rd_burst_arbiter: round-robin, whole-burst arbiter sharing one read-only burst
// slave between N requesters. Owns the slave AR/R sequencing, routes R beats to
// the granted requester, and aborts a stalled burst with an error beat.
module rd_burst_arbiter #(
    parameter int unsigned N       = 2,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned TW      = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    m_arvalid,
    input  logic [16*N-1:0] m_arin,
    output logic [N-1:0]    m_arready,
    output logic [N-1:0]    m_rvalid,
    input  logic [N-1:0]    m_rready,
    output logic [N-1:0]    m_rlast,
    output logic [9*N-1:0]  m_rdata,
    output logic            s_arvalid,
    input  logic            s_arready,
    output logic [15:0]     s_arin,
    input  logic            s_rvalid,
    output logic            s_rready,
    input  logic            s_rlast,
    input  logic [8:0]      s_rdata,
    output logic [1:0]      grant,
    output logic            busy
);

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    state_e         state_q, state_d;
    logic [1:0]     grant_q, grant_d;
    logic [1:0]     rr_q, rr_d;
    logic [15:0]    arin_q, arin_d;
    logic [N-1:0]   arready_q, arready_d;
    logic [4:0]     beat_q, beat_d;
    logic [TW-1:0]  wd_q, wd_d;

    logic           win_found;
    logic [1:0]     win_idx;
    int             cand;
    logic [3:0]     len;
    logic           last_by_len;
    logic           timeout;
    logic           beat_acc;
    logic [1:0]     rr_next;

    assign len         = arin_q[7:4];
    // len+1 beats are reached when the beat being accepted now is number len (0-based)
    assign last_by_len = (beat_q == {1'b0, len});
    assign timeout     = (state_q == StData) && (wd_q == TW'(TIMEOUT));
    assign beat_acc    = s_rvalid & s_rready;
    assign rr_next     = (grant_q == 2'(N - 1)) ? 2'd0 : grant_q + 2'd1;

    // Round-robin scan: descending loop so the lowest offset from rr wins last
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            cand = int'(rr_q) + k;
            if (cand >= int'(N)) begin
                cand = cand - int'(N);
            end
            for (int i = 0; i < int'(N); i++) begin
                if (m_arvalid[i] && (i == cand)) begin
                    win_found = 1'b1;
                    win_idx   = 2'(i);
                end
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            grant_q   <= '0;
            rr_q      <= '0;
            arin_q    <= '0;
            arready_q <= '0;
            beat_q    <= '0;
            wd_q      <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_q      <= rr_d;
            arin_q    <= arin_d;
            arready_q <= arready_d;
            beat_q    <= beat_d;
            wd_q      <= wd_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_d      = rr_q;
        arin_d    = arin_q;
        arready_d = '0;
        beat_d    = beat_q;
        wd_d      = wd_q;
        case (state_q)
            StIdle: begin
                if (win_found) begin
                    state_d = StAddr;
                    grant_d = win_idx;
                    for (int i = 0; i < int'(N); i++) begin
                        if (win_idx == 2'(i)) begin
                            arin_d       = m_arin[16*i +: 16];
                            arready_d[i] = 1'b1;
                        end
                    end
                end
            end
            StAddr: begin
                if (s_arready) begin
                    state_d = StData;
                    beat_d  = '0;
                    wd_d    = '0;
                end
            end
            StData: begin
                if (timeout) begin
                    state_d = StIdle;
                    rr_d    = rr_next;
                end else if (beat_acc) begin
                    beat_d = beat_q + 5'd1;
                    wd_d   = '0;
                    if (s_rlast || last_by_len) begin
                        state_d = StIdle;
                        rr_d    = rr_next;
                    end
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // R-channel routing to the granted requester; watchdog overrides with an error beat
    always_comb begin
        m_rvalid = '0;
        m_rlast  = '0;
        m_rdata  = '0;
        s_rready = 1'b0;
        if (state_q == StData) begin
            for (int i = 0; i < int'(N); i++) begin
                if (grant_q == 2'(i)) begin
                    if (timeout) begin
                        m_rvalid[i]        = 1'b1;
                        m_rlast[i]         = 1'b1;
                        m_rdata[9*i +: 9]  = 9'h001;
                    end else begin
                        m_rvalid[i]        = s_rvalid;
                        m_rlast[i]         = s_rlast | last_by_len;
                        m_rdata[9*i +: 9]  = s_rdata;
                        s_rready           = m_rready[i];
                    end
                end
            end
        end
    end

    assign s_arvalid = (state_q == StAddr);
    assign busy      = (state_q != StIdle);
    assign grant     = grant_q;
    assign s_arin    = arin_q;
    assign m_arready = arready_q;

endmodule

// File: tb/tb_rd_burst_arbiter.sv
// Testbench for rd_burst_arbiter (N=2): table of single-burst scenarios plus
// hand-written sequences for alternation, backpressure, watchdog and reset.
module tb_rd_burst_arbiter;

    localparam int N       = 2;
    localparam int TIMEOUT = 64;
    localparam int TW      = 7;

    logic            clk;
    logic            rst;
    logic [N-1:0]    m_arvalid;
    logic [16*N-1:0] m_arin;
    logic [N-1:0]    m_arready;
    logic [N-1:0]    m_rvalid;
    logic [N-1:0]    m_rready;
    logic [N-1:0]    m_rlast;
    logic [9*N-1:0]  m_rdata;
    logic            s_arvalid;
    logic            s_arready;
    logic [15:0]     s_arin;
    logic            s_rvalid;
    logic            s_rready;
    logic            s_rlast;
    logic [8:0]      s_rdata;
    logic [1:0]      grant;
    logic            busy;

    typedef struct {
        logic [8:0] data;
        logic       last;
    } beat_t;

    typedef struct {
        logic [1:0]  req;
        logic [15:0] a0;
        logic [15:0] a1;
        int          exp_g;
        int          slave_beats;  // 0: slave never asserts s_rlast
        int          exp_beats;
    } vec_t;

    beat_t sb_q[$];
    vec_t  vecs[6];
    int    checks;
    int    failures;

    rd_burst_arbiter #(.N(N), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .m_arvalid (m_arvalid),
        .m_arin    (m_arin),
        .m_arready (m_arready),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready),
        .m_rlast   (m_rlast),
        .m_rdata   (m_rdata),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_arin    (s_arin),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .s_rlast   (s_rlast),
        .s_rdata   (s_rdata),
        .grant     (grant),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_s_arvalid"}, s_arvalid, 0);
        check({tag, "_s_rready"}, s_rready, 0);
        check({tag, "_m_arready"}, m_arready, 0);
        check({tag, "_m_rvalid"}, m_rvalid, 0);
        check({tag, "_m_rlast"}, m_rlast, 0);
        check({tag, "_m_rdata"}, m_rdata, 0);
        check({tag, "_grant"}, grant, 0);
        check({tag, "_s_arin"}, s_arin, 0);
    endtask

    // Grant from IDLE, hold ADDR one cycle, then accept; ends in DATA
    task automatic start_burst(input logic [1:0] req, input logic [15:0] a0,
                               input logic [15:0] a1, input int exp_g, input bit hold);
        logic [15:0] exp_arin;
        exp_arin  = (exp_g == 0) ? a0 : a1;
        m_arvalid = req;
        m_arin    = {a1, a0};
        s_arready = 1'b0;
        m_rready  = '1;
        tick();
        check("grant_busy", busy, 1);
        check("grant_idx", grant, exp_g);
        check("s_arvalid_set", s_arvalid, 1);
        check("s_arin_latched", s_arin, exp_arin);
        check("m_arready_pulse", m_arready, 1 << exp_g);
        if (!hold) m_arvalid = '0;
        tick();
        check("addr_hold_valid", s_arvalid, 1);
        check("addr_hold_arin", s_arin, exp_arin);
        check("m_arready_once", m_arready, 0);
        check("addr_no_rready", s_rready, 0);
        s_arready = 1'b1;
        tick();
        s_arready = 1'b0;
        check("data_arvalid_low", s_arvalid, 0);
    endtask

    // Slave offers beats; scoreboard pushes on offer, pops on requester handshake
    task automatic data_phase(input int g, input logic [15:0] arin, input int slave_beats,
                              input bit toggle, input int exp_beats);
        int    b;
        int    seen;
        int    len;
        bit    pending;
        bit    done;
        logic  sl;
        logic  [8:0] d;
        beat_t e;
        beat_t got;
        b       = 0;
        seen    = 0;
        pending = 0;
        done    = 0;
        len     = int'(arin[7:4]);
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            if (!pending) begin
                d      = 9'($urandom_range(0, 511));
                sl     = (slave_beats != 0) && (b == slave_beats - 1);
                e.data = d;
                e.last = sl || (b == len);
                sb_q.push_back(e);
                pending  = 1;
                b++;
                s_rdata  = d;
                s_rlast  = sl;
                s_rvalid = 1'b1;
            end
            m_rready    = '0;
            m_rready[g] = toggle ? (cyc % 2 == 0) : 1'b1;
            #1;
            check("s_rready_mirror", s_rready, m_rready[g]);
            check("m_rvalid_routed", m_rvalid, 1 << g);
            check("other_rdata_zero", m_rdata[9*(1-g) +: 9], 0);
            if (m_rvalid[g] && m_rready[g]) begin
                got.data = m_rdata[9*g +: 9];
                got.last = m_rlast[g];
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL scoreboard_empty unexpected beat data=0x%0h", got.data);
                end else begin
                    e = sb_q.pop_front();
                    check("beat_data", got.data, e.data);
                    check("beat_last", got.last, e.last);
                    seen++;
                    pending = 0;
                    done    = e.last;
                end
            end
            tick();
        end
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
        s_rdata  = '0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL burst_end actual=no_last_beat required=last_within_64_cycles");
        end
        check("beat_count", seen, exp_beats);
        check("idle_after_burst", busy, 0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        m_arvalid = '0;
        m_arin    = '0;
        m_rready  = '0;
        s_arready = 1'b0;
        s_rvalid  = 1'b0;
        s_rlast   = 1'b0;
        s_rdata   = '0;

        // {req, a0, a1, exp_g, slave_beats, exp_beats}; rr carries across rows
        vecs[0] = '{2'b01, 16'h2031, 16'h0000, 0, 4, 4};   // basic 4-beat burst
        vecs[1] = '{2'b11, 16'h1100, 16'h4412, 1, 2, 2};   // rr=1 favours m1
        vecs[2] = '{2'b11, 16'h5520, 16'h0000, 0, 0, 3};   // no s_rlast, len 2 forced
        vecs[3] = '{2'b01, 16'h66F3, 16'h0000, 0, 0, 16};  // len 15, wrap scan to m0
        vecs[4] = '{2'b10, 16'h0000, 16'h7710, 1, 5, 2};   // len 1 forced before slave last
        vecs[5] = '{2'b10, 16'h0000, 16'h8850, 1, 2, 2};   // slave last before len

        #1;
        check_all_zero("reset");
        tick();
        tick();
        check_all_zero("reset_hold");
        rst = 1'b0;
        tick();
        check("idle_no_req", busy, 0);

        for (int i = 0; i < 6; i++) begin
            start_burst(vecs[i].req, vecs[i].a0, vecs[i].a1, vecs[i].exp_g, 1'b0);
            data_phase(vecs[i].exp_g, (vecs[i].exp_g == 0) ? vecs[i].a0 : vecs[i].a1,
                       vecs[i].slave_beats, 1'b0, vecs[i].exp_beats);
        end

        // Both requesters held: grants alternate 0,1,0,1
        for (int k = 0; k < 4; k++) begin
            start_burst(2'b11, 16'hA100, 16'hB101, k % 2, 1'b1);
            data_phase(k % 2, (k % 2 == 0) ? 16'hA100 : 16'hB101, 1, 1'b0, 1);
        end
        m_arvalid = '0;

        // Requester backpressure toggling during a 3-beat burst
        start_burst(2'b01, 16'h3321, 16'h0000, 0, 1'b0);
        data_phase(0, 16'h3321, 3, 1'b1, 3);

        // Slave stall: watchdog error beat, then the other requester is served
        start_burst(2'b10, 16'h0000, 16'hD230, 1, 1'b0);
        m_rready = '1;
        s_rvalid = 1'b0;
        for (int c = 0; c <= TIMEOUT; c++) begin
            #1;
            if (c < TIMEOUT) begin
                check("stall_no_rvalid", m_rvalid, 0);
            end else begin
                check("wd_rvalid", m_rvalid, 2'b10);
                check("wd_rlast", m_rlast, 2'b10);
                check("wd_rdata", m_rdata[17:9], 9'h001);
                check("wd_s_rready", s_rready, 0);
            end
            tick();
        end
        check("wd_idle", busy, 0);
        start_burst(2'b11, 16'hC400, 16'hC511, 0, 1'b0);
        data_phase(0, 16'hC400, 1, 1'b0, 1);

        // Reset during the second beat of a burst
        start_burst(2'b01, 16'h9930, 16'h0000, 0, 1'b0);
        s_rvalid = 1'b1;
        s_rdata  = 9'h0AA;
        s_rlast  = 1'b0;
        m_rready = 2'b01;
        tick();
        s_rdata = 9'h155;
        #1;
        check("pre_reset_rvalid", m_rvalid, 2'b01);
        rst = 1'b1;
        #1;
        check_all_zero("mid_reset");
        s_rvalid = 1'b0;
        s_rdata  = '0;
        tick();
        rst = 1'b0;
        sb_q.delete();
        tick();
        // rr cleared by reset, so m0 wins even though m1 also requests
        start_burst(2'b11, 16'hAA05, 16'hBB05, 0, 1'b0);
        data_phase(0, 16'hAA05, 1, 1'b0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rd_burst_arbiter.md
Name: rd_burst_arbiter

Overview:
- Shares one read-only burst memory slave between N requesters.
- Slave read protocol: AR handshake on a packed 16-bit request {addr[7:0], len[3:0], id[3:0]}, then R beats carrying 9-bit data {byte[7:0], err}.
- Grants are whole-burst and round-robin. The arbiter owns the slave AR/R handshake sequencing and routes R beats back to the granted requester.
- A per-burst watchdog frees the slave if it stalls.

Parameters:
N, 2, number of requesters (2..4)
TIMEOUT, 64, max cycles in DATA without an accepted beat before abort
TW, 7, width of watchdog counter (must satisfy 2^TW > TIMEOUT)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
m_arvalid  input  N  request valid per requester
m_arin  input  16*N  packed request per requester, requester i at [16i+15:16i]
m_arready  output  N  one-cycle accept pulse per requester
m_rvalid  output  N  read beat valid, only granted bit may be 1
m_rready  input  N  requester ready for beat
m_rlast  output  N  final beat of burst
m_rdata  output  9*N  beat data per requester, {byte, err}
s_arvalid  output  1  slave request valid
s_arready  input  1  slave request accepted
s_arin  output  16  latched request to slave
s_rvalid  input  1  slave beat valid
s_rready  output  1  ready to slave
s_rlast  input  1  slave final beat
s_rdata  input  9  slave beat data
grant  output  2  index of current owner, valid when busy=1
busy  output  1  burst in progress

Behaviour:
- Reset (async): state IDLE; all outputs 0; rr pointer = 0; beat and watchdog counters = 0.
- States: IDLE -> ADDR -> DATA -> IDLE.
- IDLE:
  - Scan m_arvalid starting at rr, wrapping modulo N; first set bit wins.
  - On a win, the next clk edge: grant = winner; busy = 1; s_arin = winner's m_arin; m_arready[winner] pulses for exactly 1 cycle; s_arvalid = 1; go to ADDR.
  - No request: stay IDLE.
- ADDR:
  - Hold s_arvalid and s_arin stable until s_arready = 1 is sampled.
  - Next edge: s_arvalid = 0; clear beat counter and watchdog; go to DATA.
  - s_rready stays 0 in ADDR.
- DATA routing (combinational, granted index g only):
  - m_rvalid[g] = s_rvalid.
  - m_rdata[g] = s_rdata.
  - m_rlast[g] = s_rlast or final beat.
  - s_rready = m_rready[g].
  - All non-granted m_rvalid/m_rlast = 0 and m_rdata = 0.
- Beat accepted = s_rvalid & s_rready; each accepted beat increments the 5-bit beat counter.
- Burst ends on an accepted beat with s_rlast = 1, or when the beat counter reaches len+1 (len from latched s_arin[7:4]); the second case forces m_rlast[g] on that beat.
- End of burst: next edge goes to IDLE; busy = 0; rr = (g+1) mod N.
- Watchdog:
  - Counts DATA cycles with no accepted beat; resets on each accepted beat.
  - Reaching TIMEOUT: for one cycle drive m_rvalid[g] = 1, m_rlast[g] = 1, m_rdata[g] = 9'h001 (error), s_rready = 0, ignoring m_rready.
  - Then go to IDLE and advance rr as normal.
- Simultaneous requests: lowest index at or after rr wins. A requester that deasserts m_arvalid before grant is simply skipped.
- m_arvalid from the granted requester during its own burst is ignored; it can win again only after the rr rotation.
- len = 0 means one beat. The beat counter is 5 bits so len = 15 (16 beats) does not overflow.
- rst mid-burst: immediate return to IDLE, all outputs 0; the slave is expected to be reset by the same rst.

Test Plan:
- Single request, m0 arin = 16'h2031 (addr 0x20, len 3, id 1), slave returns 4 beats with s_rlast on 4th -> s_arin = 16'h2031, m_arready[0] pulses once, m0 sees 4 beats and m_rlast on beat 4, busy returns to 0, rr = 1.
- m0 and m1 request together from reset -> m0 granted first, m1 granted on the next IDLE; repeat with both held -> grants alternate 0,1,0,1.
- m_rready[g] toggles 1,0,1,0 during a 3-beat burst -> s_rready mirrors it, beat count advances only on handshake cycles, no beat lost or duplicated.
- Slave never drives s_rlast, len = 1 -> arbiter forces m_rlast on 2nd accepted beat and returns to IDLE.
- Slave stalls (s_rvalid = 0) for TIMEOUT cycles in DATA -> one error beat 9'h001 with m_rlast = 1, then IDLE and next requester served.
- Assert rst during DATA beat 2 -> busy, s_arvalid, s_rready, all m_* outputs 0 the same cycle; a new request after release is granted normally.
